// File: rtl/ghost_pkg.sv
// ghost_pkg: shared mode encoding, palette colours and sprite geometry for the ghost sprite reader
package ghost_pkg;
    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        FRIGHT = 2'b01,
        BLINK  = 2'b10,
        EYES   = 2'b11
    } ghost_mode_t;
    localparam int SPRITE_SIDE = 32;
    localparam logic [11:0] C_WHITE = 12'hFFF;
    localparam logic [11:0] C_BLUE  = 12'h00F;
    localparam logic [11:0] C_PINK  = 12'hFCC;
    localparam logic [11:0] C_RED   = 12'hF00;
endpackage

// File: rtl/ghost_palette.sv
// ghost_palette: maps a 2-bit bitmap code to RGB for the given mode and blink phase
// Ports: mode_i/phase_i select the palette, code_i is the bitmap code,
//        rgb_o is the palette colour, transparent_o requests upstream pass-through.
module ghost_palette
    import ghost_pkg::*;
#(
    parameter logic [11:0] BODY_RGB = 12'hF00
) (
    input  ghost_mode_t mode_i,
    input  logic        phase_i,
    input  logic [1:0]  code_i,
    output logic [11:0] rgb_o,
    output logic        transparent_o
);
    logic frt;
    logic alt;
    // BLINK alternates between the FRIGHT palette (phase 0) and a white/red palette (phase 1)
    assign frt = mode_i == FRIGHT || (mode_i == BLINK && !phase_i);
    assign alt = mode_i == BLINK && phase_i;
    assign transparent_o = code_i == 2'b00 || (mode_i == EYES && code_i == 2'b01);
    assign rgb_o = frt ? (code_i == 2'b01 ? C_BLUE : C_PINK)
                 : alt ? (code_i == 2'b01 ? C_WHITE : C_RED)
                 : (code_i == 2'b01 ? BODY_RGB : code_i == 2'b10 ? C_WHITE : C_BLUE);
endmodule

// File: rtl/ghost_sprite_reader.sv
// ghost_sprite_reader: overlays a 32x32 ghost bitmap onto the pixel stream with frame-synchronous origin/mode updates
// Ports: x/y/si_rgb pixel stream in, frame_start frame pulse, org_*/mode_* MMIO writes,
//        ram_addr_r/ram_dout bitmap RAM read port (1-cycle latency), so_rgb pixel out (2-cycle latency).
module ghost_sprite_reader
    import ghost_pkg::*;
#(
    parameter int          CD           = 12,
    parameter int          ADDR_WIDTH   = 10,
    parameter int          DATA_WIDTH   = 2,
    parameter logic [11:0] BODY_RGB     = 12'hF00,
    parameter int          BLINK_FRAMES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  frame_start,
    input  logic [CD-1:0]         si_rgb,
    input  logic                  org_we,
    input  logic [10:0]           org_x,
    input  logic [10:0]           org_y,
    input  logic                  org_en,
    input  logic                  mode_we,
    input  logic [1:0]            mode_in,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [CD-1:0]         so_rgb
);
    localparam int H = ADDR_WIDTH / 2;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [10:0]    pend_x_q, pend_y_q, act_x_q, act_y_q;
    logic           pend_en_q, act_en_q;
    ghost_mode_t    pend_mode_q, act_mode_q, mode_d, mode_q;
    logic [BW-1:0]  blink_cnt_q;
    logic           phase_q;
    logic [11:0]    dx, dy;
    logic           hit_d, hit_q;
    logic [CD-1:0]  si_q, so_d;
    logic [CD-1:0]  pal_rgb;
    logic           pal_transparent;
    assign mode_d = ghost_mode_t'(mode_in);
    // Unsigned 12-bit differences: a pixel left of / above the origin wraps to a large value and misses
    assign dx = {1'b0, x} - {1'b0, act_x_q};
    assign dy = {1'b0, y} - {1'b0, act_y_q};
    assign hit_d = act_en_q && dx < 12'(SPRITE_SIDE) && dy < 12'(SPRITE_SIDE);
    assign ram_addr_r = {dy[H-1:0], dx[H-1:0]};
    // Pending registers take every write; active ones only move on frame_start, bypassing a same-cycle write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_en_q   <= 1'b0;
            pend_mode_q <= NORMAL;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_en_q    <= 1'b0;
            act_mode_q  <= NORMAL;
        end else begin
            if (org_we) begin
                pend_x_q  <= org_x;
                pend_y_q  <= org_y;
                pend_en_q <= org_en;
            end
            if (mode_we) pend_mode_q <= mode_d;
            if (frame_start) begin
                act_x_q    <= org_we ? org_x : pend_x_q;
                act_y_q    <= org_we ? org_y : pend_y_q;
                act_en_q   <= org_we ? org_en : pend_en_q;
                act_mode_q <= mode_we ? mode_d : pend_mode_q;
            end
        end
    end
    // Outside BLINK the counter is held clear so every entry into BLINK starts at phase 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (act_mode_q != BLINK) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (frame_start) begin
            blink_cnt_q <= blink_cnt_q == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt_q + 1'b1;
            phase_q     <= blink_cnt_q == BW'(BLINK_FRAMES - 1) ? ~phase_q : phase_q;
        end
    end
    ghost_palette #(.BODY_RGB(BODY_RGB)) u_palette (
        .mode_i        (mode_q),
        .phase_i       (phase_q),
        .code_i        (ram_dout),
        .rgb_o         (pal_rgb),
        .transparent_o (pal_transparent)
    );
    assign so_d = hit_q && !pal_transparent ? pal_rgb : si_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= 1'b0;
            si_q   <= '0;
            mode_q <= NORMAL;
            so_rgb <= '0;
        end else begin
            hit_q  <= hit_d;
            si_q   <= si_rgb;
            mode_q <= act_mode_q;
            so_rgb <= so_d;
        end
    end
endmodule

// File: tb/tb_ghost_sprite_reader.sv
// tb_ghost_sprite_reader: directed scoreboard bench for ghost_sprite_reader
module tb_ghost_sprite_reader;
    typedef struct {
        int          due;
        logic [11:0] exp;
        string       nm;
    } ent_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0, y = '0, org_x = '0, org_y = '0;
    logic        frame_start = 1'b0, org_we = 1'b0, org_en = 1'b0, mode_we = 1'b0;
    logic [1:0]  mode_in = '0;
    logic [1:0]  ram_dout = '0;
    logic [11:0] si_rgb = '0;
    logic [9:0]  ram_addr_r;
    logic [11:0] so_rgb;
    logic [1:0]  mem [1024];
    ent_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ghost_sprite_reader dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .si_rgb      (si_rgb),
        .org_we      (org_we),
        .org_x       (org_x),
        .org_y       (org_y),
        .org_en      (org_en),
        .mode_we     (mode_we),
        .mode_in     (mode_in),
        .ram_addr_r  (ram_addr_r),
        .ram_dout    (ram_dout),
        .so_rgb      (so_rgb)
    );
    always #5 clk = ~clk;
    always @(posedge clk) ram_dout <= mem[ram_addr_r];
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check(e.due == cyc ? e.nm : "late", so_rgb, e.exp);
            end
        end
    end
    task automatic idle_set();
        x = 11'd2000;
        y = 11'd2000;
        si_rgb = '0;
        frame_start = 1'b0;
        org_we = 1'b0;
        mode_we = 1'b0;
    endtask
    task automatic px(input logic [10:0] xi, input logic [10:0] yi, input logic [11:0] si, input logic [11:0] e, input string nm);
        @(negedge clk);
        idle_set();
        x = xi;
        y = yi;
        si_rgb = si;
        q.push_back(ent_t'{cyc + 2, e, nm});
    endtask
    task automatic wr_org(input logic [10:0] ox, input logic [10:0] oy, input logic en, input logic fs);
        @(negedge clk);
        idle_set();
        org_we = 1'b1;
        org_x = ox;
        org_y = oy;
        org_en = en;
        frame_start = fs;
    endtask
    task automatic wr_mode(input logic [1:0] m, input logic fs);
        @(negedge clk);
        idle_set();
        mode_we = 1'b1;
        mode_in = m;
        frame_start = fs;
    endtask
    task automatic frame();
        @(negedge clk);
        idle_set();
        frame_start = 1'b1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 2'b01;
        repeat (2) @(negedge clk);
        check("rst_so", so_rgb, 12'h000);
        check("rst_addr", ram_addr_r, 10'd0);
        reset = 1'b0;
        wr_org(11'd100, 11'd50, 1'b1, 1'b0);
        frame();
        for (int i = 0; i < 32; i++) px(11'(100 + i), 11'd50, 12'h123, 12'hF00, "scan_hit");
        px(11'd132, 11'd50, 12'h456, 12'h456, "scan_right_edge");
        px(11'd99, 11'd50, 12'h0AB, 12'h0AB, "scan_left_wrap");
        px(11'd100, 11'd82, 12'h0AC, 12'h0AC, "scan_bottom_edge");
        wr_org(11'd0, 11'd0, 1'b1, 1'b1);
        px(11'd5, 11'd3, 12'h321, 12'hF00, "addr_hit");
        #1 check("addr", ram_addr_r, 10'd101);
        wr_org(11'd10, 11'd0, 1'b1, 1'b1);
        px(11'd5, 11'd0, 12'h777, 12'h777, "wrap_miss");
        wr_org(11'd200, 11'd200, 1'b1, 1'b0);
        px(11'd10, 11'd0, 12'h111, 12'hF00, "pend_old_hit");
        px(11'd200, 11'd200, 12'h222, 12'h222, "pend_new_miss");
        frame();
        px(11'd200, 11'd200, 12'h333, 12'hF00, "act_new_hit");
        px(11'd10, 11'd0, 12'h444, 12'h444, "act_old_miss");
        @(negedge clk);
        idle_set();
        mem[0] = 2'b00;
        mem[1] = 2'b01;
        mem[2] = 2'b10;
        mem[3] = 2'b11;
        px(11'd200, 11'd200, 12'h555, 12'h555, "norm_c0");
        px(11'd201, 11'd200, 12'h555, 12'hF00, "norm_c1");
        px(11'd202, 11'd200, 12'h555, 12'hFFF, "norm_c2");
        px(11'd203, 11'd200, 12'h555, 12'h00F, "norm_c3");
        wr_mode(2'b01, 1'b1);
        px(11'd200, 11'd200, 12'h556, 12'h556, "frt_c0");
        px(11'd201, 11'd200, 12'h556, 12'h00F, "frt_c1");
        px(11'd202, 11'd200, 12'h556, 12'hFCC, "frt_c2");
        px(11'd203, 11'd200, 12'h556, 12'hFCC, "frt_c3");
        wr_mode(2'b11, 1'b1);
        px(11'd200, 11'd200, 12'h557, 12'h557, "eyes_c0");
        px(11'd201, 11'd200, 12'h557, 12'h557, "eyes_c1");
        px(11'd202, 11'd200, 12'h557, 12'hFFF, "eyes_c2");
        px(11'd203, 11'd200, 12'h557, 12'h00F, "eyes_c3");
        wr_mode(2'b10, 1'b1);
        for (int f = 0; f < 17; f++) begin
            px(11'd201, 11'd200, 12'h0C0, (f < 8 || f == 16) ? 12'h00F : 12'hFFF, "blink_c1");
            px(11'd202, 11'd200, 12'h0C0, (f < 8 || f == 16) ? 12'hFCC : 12'hF00, "blink_c2");
            px(11'd200, 11'd200, 12'h0C1, 12'h0C1, "blink_c0");
            frame();
        end
        repeat (7) frame();
        px(11'd201, 11'd200, 12'h0C2, 12'hFFF, "blink_f24");
        wr_mode(2'b00, 1'b1);
        px(11'd201, 11'd200, 12'h0C3, 12'hF00, "back_normal");
        wr_mode(2'b10, 1'b1);
        px(11'd201, 11'd200, 12'h0C4, 12'h00F, "blink_restart");
        px(11'd201, 11'd200, 12'h0C5, 12'h00F, "pre_reset");
        @(negedge clk);
        idle_set();
        reset = 1'b1;
        q.delete();
        #1 check("midreset_so", so_rgb, 12'h000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        px(11'd1, 11'd0, 12'h9A9, 12'h9A9, "post_rst_dis");
        frame();
        px(11'd1, 11'd0, 12'h9AA, 12'h9AA, "post_rst_fs_dis");
        wr_org(11'd0, 11'd0, 1'b1, 1'b0);
        px(11'd1, 11'd0, 12'h9AB, 12'h9AB, "post_rst_pend");
        frame();
        px(11'd1, 11'd0, 12'h9AC, 12'hF00, "post_rst_en");
        repeat (4) begin
            @(negedge clk);
            idle_set();
        end
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
